// File: rtl/booth8_seq_mult.sv
// Iterative unsigned WIDTH x WIDTH multiplier built around one shared radix-8 Booth
// partial-product stage, consuming one 3-bit Booth window of the multiplier per clock.
module booth8_seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int NSTEP = (WIDTH + 3) / 3;
  localparam int YW    = 3 * NSTEP + 1;
  localparam int MW    = WIDTH + 2;
  localparam int ACCW  = 2 * WIDTH + 3;
  localparam int SW    = $clog2(NSTEP + 1);
  localparam int SHW   = $clog2(3 * NSTEP);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  x;
  logic [MW-1:0]     three_x;
  logic [YW-1:0]     y_sh;      // multiplier with Y[-1] at bit 0, shifted 3 per step
  logic [ACCW-1:0]   acc;
  logic [SW-1:0]     step;
  logic [SHW-1:0]    sh;

  logic [3:0]        win;
  logic [MW-1:0]     mag;
  logic              neg;
  logic [ACCW-1:0]   pp_ext;
  logic [ACCW-1:0]   cin;
  logic [ACCW-1:0]   acc_next;

  assign win = y_sh[3:0];

  // NOTE: every variable assigned in a combinational block gets a default first so no latch is inferred.
  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (win)
      4'b0001, 4'b0010: mag = MW'(x);
      4'b0011, 4'b0100: mag = MW'({x, 1'b0});
      4'b0101, 4'b0110: mag = three_x;
      4'b0111:          mag = MW'({x, 2'b00});
      4'b1000:          begin mag = MW'({x, 2'b00}); neg = 1'b1; end
      4'b1001, 4'b1010: begin mag = three_x;         neg = 1'b1; end
      4'b1011, 4'b1100: begin mag = MW'({x, 1'b0});  neg = 1'b1; end
      4'b1101, 4'b1110: begin mag = MW'(x);          neg = 1'b1; end
      // 0000 and 1111 are digit 0: no complement, so nothing at all is added.
      default:          begin mag = '0;              neg = 1'b0; end
    endcase
  end

  // Ones' complement of the zero-extended magnitude is its sign-extended negation minus one;
  // the missing +1 enters at the same weight as the partial product.
  assign pp_ext   = {{(ACCW-MW){1'b0}}, mag} ^ {ACCW{neg}};
  assign cin      = {{(ACCW-1){1'b0}}, neg};
  assign acc_next = acc + (pp_ext << sh) + (cin << sh);

  assign out_p = acc[2*WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      x         <= '0;
      three_x   <= '0;
      y_sh      <= '0;
      acc       <= '0;
      step      <= '0;
      sh        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            x        <= in_a;
            y_sh     <= {{(YW-1-WIDTH){1'b0}}, in_b, 1'b0};
            acc      <= '0;
            step     <= '0;
            sh       <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          three_x <= MW'(x) + MW'({x, 1'b0});
          state   <= S_RUN;
        end
        S_RUN: begin
          acc  <= acc_next;
          y_sh <= y_sh >> 3;
          step <= step + SW'(1);
          sh   <= sh + SHW'(3);
          if (step == SW'(NSTEP - 1)) begin
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
